// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register and a
// saturating debug counter of cycles in which the PC failed to advance.
module fetch_stage #(
  parameter int                      PC_WIDTH    = 8,
  parameter int                      INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]     RESET_PC    = '0,
  parameter int                      PC_INC      = 1,
  parameter logic [INSTR_WIDTH-1:0]  NOP_INSTR   = '0,
  parameter int                      CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pc_write,
  input  logic                   IFID_write,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_target,
  input  logic                   imem_ready,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic [PC_WIDTH-1:0]    imem_addr,
  output logic                   imem_req,
  output logic [INSTR_WIDTH-1:0] ifid_instr,
  output logic [PC_WIDTH-1:0]    ifid_pc_next,
  output logic                   ifid_valid,
  output logic [CNT_WIDTH-1:0]   stall_cycles
);

  logic [PC_WIDTH-1:0]    pc_q, pc_d, pc_inc;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [PC_WIDTH-1:0]    pc_next_q, pc_next_d;
  logic                   valid_q, valid_d;
  logic [CNT_WIDTH-1:0]   stall_q, stall_d;
  logic                   fetch_ok;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  assign pc_inc   = pc_q + PC_WIDTH'(PC_INC);
  assign fetch_ok = pc_write && imem_ready;

  // PC stage: redirect beats the load-use hold and memory wait
  always_comb begin
    pc_d = pc_q;
    if (branch_taken)  pc_d = branch_target;
    else if (fetch_ok) pc_d = pc_inc;
  end

  // IF/ID stage: flush beats freeze; a freeze also holds a bubble
  always_comb begin
    instr_d   = instr_q;
    pc_next_d = pc_next_q;
    valid_d   = valid_q;
    if (branch_taken) begin
      instr_d   = NOP_INSTR;
      pc_next_d = '0;
      valid_d   = 1'b0;
    end else if (IFID_write) begin
      if (imem_ready) begin
        instr_d   = imem_rdata;
        pc_next_d = pc_inc;
        valid_d   = 1'b1;
      end else begin
        instr_d   = NOP_INSTR;
        pc_next_d = '0;
        valid_d   = 1'b0;
      end
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (!branch_taken && !fetch_ok) stall_d = sat_inc(stall_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      instr_q   <= NOP_INSTR;
      pc_next_q <= '0;
      valid_q   <= 1'b0;
      stall_q   <= '0;
    end else begin
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      pc_next_q <= pc_next_d;
      valid_q   <= valid_d;
      stall_q   <= stall_d;
    end
  end

  assign imem_addr    = pc_q;
  assign imem_req     = ~rst;
  assign ifid_instr   = instr_q;
  assign ifid_pc_next = pc_next_q;
  assign ifid_valid   = valid_q;
  assign stall_cycles = stall_q;

endmodule
